// File: rtl/btb_pkg.sv
// Shared definitions for the branch target buffer.
// Holds helper functions, default configuration values and entry field
// offsets. These offsets apply when an entry is stored as a packed
// {valid, tag, target, ctr} vector.
package btb_pkg;

    // Default configuration
    localparam int BTB_PC_W    = 32;
    localparam int BTB_ENTRIES = 32;
    localparam int BTB_CTR_W   = 2;

    // Ceiling log2, usable in constant expressions
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Weakly-taken counter value for a given counter width
    function automatic int ctr_weak_taken(input int ctr_w);
        return 1 << (ctr_w - 1);
    endfunction

    // Weakly-taken and weakly-not-taken values for the default counter width
    localparam int CTR_WEAK_T  = ctr_weak_taken(BTB_CTR_W);
    localparam int CTR_WEAK_NT = CTR_WEAK_T - 1;

    // Field offsets of a packed entry {valid, tag, target, ctr}, counter in the LSBs
    function automatic int ent_ctr_lsb();
        return 0;
    endfunction

    function automatic int ent_target_lsb(input int ctr_w);
        return ctr_w;
    endfunction

    function automatic int ent_tag_lsb(input int ctr_w, input int pc_w);
        return ctr_w + pc_w;
    endfunction

    function automatic int ent_valid_bit(input int ctr_w, input int pc_w, input int tag_w);
        return ctr_w + pc_w + tag_w;
    endfunction

    function automatic int ent_width(input int ctr_w, input int pc_w, input int tag_w);
        return ctr_w + pc_w + tag_w + 1;
    endfunction

endpackage

// File: rtl/sat_counter_upd.sv
// Combinational saturating up/down counter step.
// dir = 1 counts up and holds at all-ones. dir = 0 counts down and holds at zero.
module sat_counter_upd
    import btb_pkg::*;
#(
    parameter int CTR_W = BTB_CTR_W
) (
    input  logic [CTR_W-1:0] ctr,
    input  logic             dir,
    output logic [CTR_W-1:0] ctr_next
);

    // Step the counter one position toward the branch outcome, clamped at both ends
    always_comb begin
        ctr_next = ctr;
        if (dir) begin
            if (ctr != {CTR_W{1'b1}}) begin
                ctr_next = ctr + CTR_W'(1);
            end
        end else begin
            if (ctr != {CTR_W{1'b0}}) begin
                ctr_next = ctr - CTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/btb_predictor.sv
// Branch target buffer with per-entry saturating direction counters.
// The IF stage does a combinational lookup on lookup_pc. The MEM stage
// writes back the resolved outcome and target on the clock edge.
// Optional build macro BTB_STATS_EN adds the lookup, hit and allocation
// statistics counters.
module btb_predictor
    import btb_pkg::*;
#(
    parameter int PC_W    = BTB_PC_W,
    parameter int ENTRIES = BTB_ENTRIES,
    parameter int CTR_W   = BTB_CTR_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] lookup_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
    input  logic            flush_all
`ifdef BTB_STATS_EN
    ,
    output logic [31:0]     stat_lookups,
    output logic [31:0]     stat_hits,
    output logic [31:0]     stat_allocs
`endif
);

    localparam int IDX_W = clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W;

    localparam logic [CTR_W-1:0] WEAK_T  = CTR_W'(ctr_weak_taken(CTR_W));
    localparam logic [CTR_W-1:0] WEAK_NT = CTR_W'(ctr_weak_taken(CTR_W) - 1);

    // Table storage, one array per field; valid is a flat vector so a flush clears it in one edge
    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [PC_W-1:0]    target_q [ENTRIES];
    logic [CTR_W-1:0]   ctr_q    [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic             do_update;
    logic             do_alloc;
    logic [CTR_W-1:0] ctr_stepped;

    assign lk_idx  = lookup_pc[IDX_W-1:0];
    assign lk_tag  = lookup_pc[PC_W-1:IDX_W];
    assign upd_idx = upd_pc[IDX_W-1:0];
    assign upd_tag = upd_pc[PC_W-1:IDX_W];

    // Lookup reads the registered table only, so a same-cycle update is not forwarded
    always_comb begin
        pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken  = pred_hit && ctr_q[lk_idx][CTR_W-1];
        pred_target = pred_taken ? target_q[lk_idx] : lookup_pc + PC_W'(1);
    end

    // Classify the resolved branch; a flush in the same cycle discards it
    always_comb begin
        upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        do_update = upd_valid && !flush_all && upd_hit;
        do_alloc  = upd_valid && !flush_all && !upd_hit && upd_taken;
    end

    sat_counter_upd #(
        .CTR_W(CTR_W)
    ) u_ctr_upd (
        .ctr      (ctr_q[upd_idx]),
        .dir      (upd_taken),
        .ctr_next (ctr_stepped)
    );

    // Valid bits: cleared by reset or flush, set on allocation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (flush_all) begin
            valid_q <= '0;
        end else if (do_alloc) begin
            valid_q[upd_idx] <= 1'b1;
        end
    end

    // Entry payload: counter training on hits, full overwrite on a taken miss
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= WEAK_NT;
            end
        end else if (do_update) begin
            ctr_q[upd_idx] <= ctr_stepped;
            if (upd_taken) begin
                target_q[upd_idx] <= upd_target;
            end
        end else if (do_alloc) begin
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= upd_target;
            ctr_q[upd_idx]    <= WEAK_T;
        end
    end

`ifdef BTB_STATS_EN
    // Statistics counters: free-running, wrap at 2^32, untouched by flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_lookups <= '0;
            stat_hits    <= '0;
            stat_allocs  <= '0;
        end else begin
            stat_lookups <= stat_lookups + 32'd1;
            if (pred_hit) begin
                stat_hits <= stat_hits + 32'd1;
            end
            if (do_alloc) begin
                stat_allocs <= stat_allocs + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_btb_predictor.sv
// Directed testbench for btb_predictor in its default configuration
// (32 entries, 2-bit counters). Define BTB_STATS_EN to also cover the
// statistics counters.
module tb_btb_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] lookup_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        flush_all;
`ifdef BTB_STATS_EN
    logic [31:0] stat_lookups;
    logic [31:0] stat_hits;
    logic [31:0] stat_allocs;
`endif

    int total;
    int bad;

    btb_predictor dut (
        .clk         (clk),
        .rst         (rst),
        .lookup_pc   (lookup_pc),
        .pred_hit    (pred_hit),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target),
        .flush_all   (flush_all)
`ifdef BTB_STATS_EN
        ,
        .stat_lookups(stat_lookups),
        .stat_hits   (stat_hits),
        .stat_allocs (stat_allocs)
`endif
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and leave the inputs quiet
    task automatic step();
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        flush_all = 1'b0;
    endtask

    // Present one resolved branch for the next edge
    task automatic drive_upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_taken  = taken;
        upd_target = tgt;
    endtask

    // Compare the three prediction outputs for the current lookup_pc
    task automatic look(input string name, input logic [31:0] pc,
                        input logic eh, input logic et, input logic [31:0] etgt);
        lookup_pc = pc;
        #1;
        total++;
        if (pred_hit !== eh) begin
            $display("[TB] FAIL %s hit: got %b want %b", name, pred_hit, eh);
            bad++;
        end
        total++;
        if (pred_taken !== et) begin
            $display("[TB] FAIL %s taken: got %b want %b", name, pred_taken, et);
            bad++;
        end
        total++;
        if (pred_target !== etgt) begin
            $display("[TB] FAIL %s target: got %h want %h", name, pred_target, etgt);
            bad++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        upd_valid = 1'b0; flush_all = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        #1;
        look("reset_in", 32'h40, 1'b0, 1'b0, 32'h41);
        @(posedge clk); #1;
        rst = 1'b0;
        look("reset_out", 32'h40, 1'b0, 1'b0, 32'h41);
    endtask

    task automatic test_alloc();
        drive_upd(32'h40, 1'b1, 32'h10);
        step();
        look("alloc_hit", 32'h40, 1'b1, 1'b1, 32'h10);
        look("alloc_alias", 32'h60, 1'b0, 1'b0, 32'h61);
    endtask

    task automatic test_saturate();
        // 2 -> 1 -> 0 -> 0
        for (int i = 0; i < 3; i++) begin
            drive_upd(32'h40, 1'b0, 32'hDEAD);
            step();
        end
        look("sat_low", 32'h40, 1'b1, 1'b0, 32'h41);
        // 0 -> 1: still not taken
        drive_upd(32'h40, 1'b1, 32'h20);
        step();
        look("sat_up1", 32'h40, 1'b1, 1'b0, 32'h41);
        // 1 -> 2: taken, target follows the latest taken update
        drive_upd(32'h40, 1'b1, 32'h22);
        step();
        look("sat_up2", 32'h40, 1'b1, 1'b1, 32'h22);
    endtask

    task automatic test_same_cycle();
        drive_upd(32'h40, 1'b0, 32'h0);
        look("same_pre", 32'h40, 1'b1, 1'b1, 32'h22);
        step();
        look("same_post", 32'h40, 1'b1, 1'b0, 32'h41);
    endtask

    task automatic test_no_alloc();
        drive_upd(32'h0A, 1'b0, 32'h55);
        step();
        look("miss_nt", 32'h0A, 1'b0, 1'b0, 32'h0B);
    endtask

    task automatic test_flush();
        flush_all = 1'b1;
        drive_upd(32'h05, 1'b1, 32'h99);
        step();
        look("flush_40", 32'h40, 1'b0, 1'b0, 32'h41);
        look("flush_05", 32'h05, 1'b0, 1'b0, 32'h06);
        drive_upd(32'h05, 1'b1, 32'h77);
        step();
        look("realloc", 32'h05, 1'b1, 1'b1, 32'h77);
        // Allocation lands at weakly taken: one not-taken drops it below the MSB
        drive_upd(32'h05, 1'b0, 32'h0);
        step();
        look("realloc_weak", 32'h05, 1'b1, 1'b0, 32'h06);
    endtask

    task automatic test_alias_evict();
        drive_upd(32'h40, 1'b1, 32'h123);
        step();
        drive_upd(32'h60, 1'b1, 32'h456);
        step();
        look("evict_new", 32'h60, 1'b1, 1'b1, 32'h456);
        look("evict_old", 32'h40, 1'b0, 1'b0, 32'h41);
    endtask

    task automatic test_wrap();
        look("wrap", 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000);
    endtask

    task automatic test_mid_reset();
        look("mid_pre", 32'h60, 1'b1, 1'b1, 32'h456);
        rst = 1'b1;
        drive_upd(32'h60, 1'b1, 32'h789);
        flush_all = 1'b1;
        look("mid_async", 32'h60, 1'b0, 1'b0, 32'h61);
        @(posedge clk); #1;
        look("mid_hold", 32'h60, 1'b0, 1'b0, 32'h61);
        upd_valid = 1'b0;
        flush_all = 1'b0;
        rst = 1'b0;
        look("mid_after", 32'h05, 1'b0, 1'b0, 32'h06);
    endtask

`ifdef BTB_STATS_EN
    task automatic test_stats();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        lookup_pc = 32'h40;
        drive_upd(32'h40, 1'b1, 32'h10);
        step();
        lookup_pc = 32'h40;
        step();
        lookup_pc = 32'h13;
        step();
        step();
        total++;
        if (stat_lookups !== 32'd4) begin
            $display("[TB] FAIL stat_lookups: got %0d want 4", stat_lookups);
            bad++;
        end
        total++;
        if (stat_hits !== 32'd1) begin
            $display("[TB] FAIL stat_hits: got %0d want 1", stat_hits);
            bad++;
        end
        total++;
        if (stat_allocs !== 32'd1) begin
            $display("[TB] FAIL stat_allocs: got %0d want 1", stat_allocs);
            bad++;
        end
    endtask
`endif

    initial begin
        total = 0;
        bad = 0;
        lookup_pc = '0;
        test_reset();
        test_alloc();
        test_saturate();
        test_same_cycle();
        test_no_alloc();
        test_flush();
        test_alias_evict();
        test_wrap();
        test_mid_reset();
`ifdef BTB_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
- Parametrised branch target buffer with per-entry saturating direction counters, for the IF stage of the 5-stage RV32I pipeline.
- IF stage: combinational lookup on the current PC gives predicted next PC and taken flag.
- MEM stage: branch resolution writes back outcome and target.
- Replaces the unused fixed 32x35 btb array in the top level with a configurable, self-updating structure.

Parameters:
- PC_W, 32, PC width in bits; PC is word-addressed (sequential PC = PC + 1).
- ENTRIES, 32, table depth; power of 2, minimum 2; IDX_W = log2(ENTRIES).
- CTR_W, 2, saturating counter width, 1..4.
- TAG_W, PC_W-IDX_W, stored tag width (derived).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- lookup_pc  in  PC_W  IF-stage PC.
- pred_hit  out  1  valid entry with matching tag.
- pred_taken  out  1  pred_hit AND counter MSB set.
- pred_target  out  PC_W  predicted next PC.
- upd_valid  in  1  resolved branch present this cycle.
- upd_pc  in  PC_W  PC of resolved branch.
- upd_taken  in  1  actual branch outcome.
- upd_target  in  PC_W  actual branch target (PC + offset).
- flush_all  in  1  synchronous invalidate of the whole table.

Behaviour:
- Index = pc[IDX_W-1:0]; tag = pc[PC_W-1:IDX_W]. Entry = {valid, tag, target, ctr}.
- Lookup is purely combinational, zero latency from lookup_pc.
  - pred_hit = valid[idx] & (tag[idx] == lookup tag).
  - pred_target = target[idx] when pred_taken, else lookup_pc + 1 (wraps modulo 2^PC_W).
- Update happens on the rising edge when upd_valid = 1.
  - Hit, taken: ctr += 1, saturating at 2^CTR_W-1; target <= upd_target.
  - Hit, not taken: ctr -= 1, saturating at 0; target unchanged.
  - Miss, taken: allocate by overwriting the slot. valid <= 1, tag and target written, ctr <= 2^(CTR_W-1) (weakly taken).
  - Miss, not taken: no change; no allocation.
- Counter semantics: CTR_W = 1 gives last-outcome prediction.
- Reset (async): all valid <= 0, all ctr <= 2^(CTR_W-1)-1 (weakly not-taken), tags/targets <= 0. Outputs immediately read pred_hit = 0, pred_taken = 0, pred_target = lookup_pc+1.
- flush_all: on the next edge all valid <= 0; counters and targets keep their values.
- flush_all and upd_valid in the same cycle: flush wins; the update is discarded.
- Lookup and update to the same index in the same cycle: lookup returns pre-update contents; no write-through bypass. New contents are visible the cycle after the edge.
- Aliasing: same index, different tag is a miss; a taken update evicts the old entry.
- Reset asserted mid-operation clears state regardless of upd_valid or flush_all.
- No stall input: the pipeline holds lookup_pc stable during stalls. Lookup is side-effect-free.

Optional Feature:
- Macro BTB_STATS_EN.
- Defined: adds outputs stat_lookups, stat_hits, stat_allocs, each 32 bits.
  - stat_lookups increments on every clock edge (not in reset).
  - stat_hits increments when pred_hit = 1.
  - stat_allocs increments on each miss-taken allocation.
  - All counters wrap at 2^32, reset to 0, and are unaffected by flush_all.
- Undefined: ports and logic are absent; functional behaviour is identical.

Decomposition:
- Shared package btb_pkg holds:
  - function clog2;
  - localparams CTR_WEAK_T = 2^(CTR_W-1) and CTR_WEAK_NT = CTR_WEAK_T-1;
  - entry field offsets, for use when the entry is stored as a packed vector.
- One sub-module, sat_counter_upd.
  - Combinational: in ctr, dir, out ctr; saturating at both ends.
  - Instantiated once on the update path.
- Table storage stays inline as per-field arrays (valid bits as a flop vector to allow single-cycle flush).

Test Plan:
- Reset then lookup_pc=0x40 -> pred_hit=0, pred_taken=0, pred_target=0x41.
- Update pc=0x40 taken target=0x10 (ENTRIES=32, CTR_W=2), next cycle lookup 0x40 -> hit=1, taken=1 (ctr=2), target=0x10. Lookup 0x60 (same index, different tag) -> hit=0.
- Three not-taken updates at 0x40 -> ctr 2→1→0→0 (saturates). Lookup -> hit=1, taken=0, target=0x41. Then two taken updates -> ctr 1→2, taken=1.
- Lookup 0x40 and update 0x40 not-taken in the same cycle with ctr=2 -> that cycle taken=1; next cycle taken=0.
- flush_all together with upd_valid taken for pc=0x05 -> next cycle lookups of 0x40 and 0x05 both miss. A later taken allocate at 0x05 -> ctr=2.
- lookup_pc=0xFFFFFFFF on a miss -> pred_target=0x00000000. With BTB_STATS_EN: 4 lookup edges, 1 hit, 1 alloc -> stats 4/1/1.
